alu_issue: RTL and testbench

Initiator side of the execute-stage ALU handshake. Accepts one decoded OP / OP-IMM instruction from decode and builds the ALU operands and fun3/fun7. Drives the ALU `start`/`done` protocol, including a timeout guard, and hands the captured result to writeback over a valid/ready interface. It sits between the decoder and the ALU and is the only block that toggles the ALU's `start`.

---
 rtl/alu_issue.sv | 205 ++++++++++++++++++++
 tb/tb_alu_issue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Execute-stage ALU issue block: accepts one OP/OP-IMM instruction, builds the ALU operands,
// runs the start/done handshake with a timeout guard and hands the result to writeback.
module alu_issue #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_fun3,
    input  logic [6:0]  in_fun7,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [11:0] in_imm,
    input  logic [4:0]  in_rd,
    output logic        alu_start,
    output logic [2:0]  alu_fun3,
    output logic [6:0]  alu_fun7,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_res,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        alu_done,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_we,
    output logic        wb_zero,
    output logic        wb_neg,
    output logic        wb_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        start_q, start_d;
    logic [2:0]  fun3_q, fun3_d;
    logic [6:0]  fun7_q, fun7_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_we_q, wb_we_d;
    logic        wb_zero_q, wb_zero_d;
    logic        wb_neg_q, wb_neg_d;
    logic        wb_err_q, wb_err_d;

    logic        is_op, is_opimm, is_shift;
    logic [31:0] op_b;
    logic [6:0]  op_fun7;

    // Shifts (fun3 001/101) only use the low 5 bits of the amount; for OP-IMM
    // shifts the upper immediate bits carry the SRA/SRL selector.
    assign is_op    = (in_opcode == OPC_OP);
    assign is_opimm = (in_opcode == OPC_OPIMM);
    assign is_shift = (in_fun3[1:0] == 2'b01);

    always_comb begin
        op_b    = in_rs2;
        op_fun7 = in_fun7;
        if (is_op) begin
            if (is_shift) op_b = {27'b0, in_rs2[4:0]};
        end else if (is_shift) begin
            op_b    = {27'b0, in_imm[4:0]};
            op_fun7 = in_imm[11:5];
        end else begin
            op_b    = {{20{in_imm[11]}}, in_imm};
            op_fun7 = 7'b0;
        end
    end

    // A stale done from the previous operation blocks acceptance so start never rises on it.
    assign in_ready = ~reset & (state_q == IDLE) & ~alu_done;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        start_d    = start_q;
        fun3_d     = fun3_q;
        fun7_d     = fun7_q;
        a_d        = a_q;
        b_d        = b_q;
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_we_d    = wb_we_q;
        wb_zero_d  = wb_zero_q;
        wb_neg_d   = wb_neg_q;
        wb_err_d   = wb_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    wb_rd_d = in_rd;
                    if (is_op || is_opimm) begin
                        a_d     = in_rs1;
                        b_d     = op_b;
                        fun3_d  = in_fun3;
                        fun7_d  = op_fun7;
                        start_d = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = RUN;
                    end else begin
                        wb_err_d   = 1'b1;
                        wb_we_d    = 1'b0;
                        wb_data_d  = 32'd0;
                        wb_zero_d  = 1'b0;
                        wb_neg_d   = 1'b0;
                        wb_valid_d = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            RUN: begin
                // done takes priority over an expiring timeout
                if (alu_done) begin
                    wb_data_d  = alu_res;
                    wb_zero_d  = alu_zero;
                    wb_neg_d   = alu_neg;
                    wb_we_d    = (wb_rd_q != 5'd0);
                    wb_err_d   = 1'b0;
                    start_d    = 1'b0;
                    wb_valid_d = 1'b1;
                    state_d    = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    start_d    = 1'b0;
                    wb_err_d   = 1'b1;
                    wb_we_d    = 1'b0;
                    wb_data_d  = 32'd0;
                    wb_zero_d  = 1'b0;
                    wb_neg_d   = 1'b0;
                    wb_valid_d = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (wb_ready) begin
                    wb_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            start_q    <= 1'b0;
            fun3_q     <= 3'd0;
            fun7_q     <= 7'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            wb_we_q    <= 1'b0;
            wb_zero_q  <= 1'b0;
            wb_neg_q   <= 1'b0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            fun3_q     <= fun3_d;
            fun7_q     <= fun7_d;
            a_q        <= a_d;
            b_q        <= b_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_we_q    <= wb_we_d;
            wb_zero_q  <= wb_zero_d;
            wb_neg_q   <= wb_neg_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign alu_start = start_q;
    assign alu_fun3  = fun3_q;
    assign alu_fun7  = fun7_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign wb_we     = wb_we_q;
    assign wb_zero   = wb_zero_q;
    assign wb_neg    = wb_neg_q;
    assign wb_err    = wb_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue.sv
// Randomized and directed bench for alu_issue; the ALU side is played by the bench itself.
module tb_alu_issue;

    localparam int TO = 16;
    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPIMM = 7'b0010011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_fun3 = '0;
    logic [6:0]  in_fun7 = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [11:0] in_imm = '0;
    logic [4:0]  in_rd = '0;
    logic        alu_start;
    logic [2:0]  alu_fun3;
    logic [6:0]  alu_fun7;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res = '0;
    logic        alu_zero = 1'b0;
    logic        alu_neg = 1'b0;
    logic        alu_done = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        wb_zero;
    logic        wb_neg;
    logic        wb_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_issue #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_fun3(in_fun3), .in_fun7(in_fun7), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_rd(in_rd),
        .alu_start(alu_start), .alu_fun3(alu_fun3), .alu_fun7(alu_fun7),
        .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res), .alu_zero(alu_zero),
        .alu_neg(alu_neg), .alu_done(alu_done),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_we(wb_we), .wb_zero(wb_zero), .wb_neg(wb_neg), .wb_err(wb_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model: operand rules expressed as plain arithmetic.
    function automatic logic [31:0] model_b(input logic [6:0] opc, input logic [2:0] f3,
                                            input logic [31:0] rs2, input logic [11:0] imm);
        logic shift;
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        if (opc == OP) return shift ? rs2 % 32 : rs2;
        if (shift) return 32'(imm) % 32;
        return (imm >= 12'd2048) ? 32'(imm) - 32'd4096 : 32'(imm);
    endfunction

    function automatic logic [6:0] model_f7(input logic [6:0] opc, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [11:0] imm);
        if (opc == OP) return f7;
        if (f3 == 3'd1 || f3 == 3'd5) return 7'(imm / 32);
        return 7'd0;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return f7[5] ? a - b : a + b;
            3'd1: return a << (b % 32);
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return f7[5] ? 32'($signed(a) >>> (b % 32)) : a >> (b % 32);
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic check_wb(input string ph, input logic eerr, input logic ewe,
                            input logic [31:0] edata, input logic ez, input logic en,
                            input logic [4:0] erd);
        chk({ph, "_wb_valid"}, 32'(wb_valid), 32'd1);
        chk({ph, "_wb_err"},   32'(wb_err),   32'(eerr));
        chk({ph, "_wb_we"},    32'(wb_we),    32'(ewe));
        chk({ph, "_wb_data"},  wb_data,       edata);
        chk({ph, "_wb_zero"},  32'(wb_zero),  32'(ez));
        chk({ph, "_wb_neg"},   32'(wb_neg),   32'(en));
        chk({ph, "_wb_rd"},    32'(wb_rd),    32'(erd));
        chk({ph, "_start_lo"}, 32'(alu_start), 32'd0);
        chk({ph, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({ph, "_busy"},     32'(busy),     32'd1);
    endtask

    // lat: 0 = ALU never answers, otherwise done is high by the lat-th edge after accept.
    task automatic do_txn(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [11:0] imm,
                          input logic [4:0] rd, input int lat, input int wbd);
        logic        eerr, ewe, ez, en;
        logic [31:0] eb, res, edata;
        logic [6:0]  ef7;
        int          cycles;
        string       kind;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_opcode = opc; in_fun3 = f3; in_fun7 = f7;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_rd = rd;
        @(posedge clk); #1;
        in_valid = 1'b0; in_rs1 = $urandom; in_rs2 = $urandom; in_imm = 12'($urandom);
        in_rd = 5'($urandom); in_fun3 = 3'($urandom); in_fun7 = 7'($urandom);
        cycles = 0;
        if (!((opc == OP) || (opc == OPIMM))) begin
            eerr = 1'b1; ewe = 1'b0; edata = 32'd0; ez = 1'b0; en = 1'b0; kind = "UNSUP";
        end else begin
            eb  = model_b(opc, f3, rs2, imm);
            ef7 = model_f7(opc, f3, f7, imm);
            res = alu_ref(f3, ef7, rs1, eb);
            chk("start_hi", 32'(alu_start), 32'd1);
            chk("alu_a", alu_a, rs1);
            chk("alu_b", alu_b, eb);
            chk("alu_fun3", 32'(alu_fun3), 32'(f3));
            chk("alu_fun7", 32'(alu_fun7), 32'(ef7));
            chk("busy_run", 32'(busy), 32'd1);
            chk("wb_valid_run", 32'(wb_valid), 32'd0);
            cycles = 1;
            if (lat == 0) begin
                for (int i = 1; i < TO; i++) begin
                    @(posedge clk); #1;
                    chk("start_hold", 32'(alu_start), 32'd1);
                    chk("wb_valid_wait", 32'(wb_valid), 32'd0);
                    if (alu_start) cycles++;
                end
                @(posedge clk); #1;
                eerr = 1'b1; ewe = 1'b0; edata = 32'd0; ez = 1'b0; en = 1'b0; kind = "TIMEOUT";
            end else begin
                for (int i = 1; i < lat; i++) begin
                    @(posedge clk); #1;
                    chk("start_hold", 32'(alu_start), 32'd1);
                    chk("alu_b_stable", alu_b, eb);
                    if (alu_start) cycles++;
                end
                alu_done = 1'b1; alu_res = res; alu_zero = (res == 32'd0); alu_neg = res[31];
                @(posedge clk); #1;
                eerr = 1'b0; ewe = (rd != 5'd0); edata = res; ez = (res == 32'd0); en = res[31];
                kind = "DONE";
            end
            chk("start_drop", 32'(alu_start), 32'd0);
            alu_done = 1'b0; alu_res = $urandom; alu_zero = 1'b0; alu_neg = 1'b0;
        end
        check_wb("resp", eerr, ewe, edata, ez, en, rd);
        for (int i = 0; i < wbd; i++) begin
            @(posedge clk); #1;
            check_wb("hold", eerr, ewe, edata, ez, en, rd);
        end
        wb_ready = 1'b1;
        @(posedge clk); #1;
        wb_ready = 1'b0;
        chk("wb_valid_clr", 32'(wb_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("in_ready_after", 32'(in_ready), 32'd1);
        $display("txn %-7s opc=%02h f3=%0d rs1=%08h b=%08h rd=%0d start_cycles=%0d data=%08h err=%0b we=%0b",
                 kind, opc, f3, rs1, eb, rd, cycles, wb_data_snapshot(edata), eerr, ewe);
    endtask

    function automatic logic [31:0] wb_data_snapshot(input logic [31:0] d);
        return d;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] opc;
        logic [6:0] bad_opc [4];
        int r, lat;
        bad_opc[0] = 7'b0110111; bad_opc[1] = 7'b0000011;
        bad_opc[2] = 7'b1100011; bad_opc[3] = 7'b1111111;

        #12;
        chk("rst_start", 32'(alu_start), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        @(negedge clk); reset = 1'b0;
        #1 chk("rst_rel_in_ready", 32'(in_ready), 32'd1);

        do_txn(OP,    3'd0, 7'h00, 32'd7, 32'd5, 12'h000, 5'd3, 1, 0);
        do_txn(OPIMM, 3'd0, 7'h00, 32'd5, 32'd0, 12'hFFF, 5'd9, 1, 0);
        do_txn(OPIMM, 3'd0, 7'h00, 32'd5, 32'd0, 12'hFFF, 5'd0, 2, 0);
        do_txn(OPIMM, 3'd5, 7'h00, 32'h80000000, 32'd0, 12'h405, 5'd4, 1, 0);
        do_txn(OP,    3'd1, 7'h00, 32'd1, 32'h23, 12'h000, 5'd6, 3, 0);
        do_txn(OP,    3'd0, 7'h20, 32'd3, 32'd3, 12'h000, 5'd7, 1, 0);
        do_txn(OP,    3'd0, 7'h00, 32'd1, 32'd2, 12'h000, 5'd8, 0, 0);
        do_txn(OP,    3'd4, 7'h00, 32'd1, 32'd2, 12'h000, 5'd8, TO, 0);
        do_txn(OP,    3'd6, 7'h00, 32'hF0, 32'h0F, 12'h000, 5'd2, 2, 5);
        do_txn(7'b0110111, 3'd0, 7'h00, 32'd1, 32'd2, 12'h000, 5'd5, 1, 2);

        // stale done in IDLE blocks acceptance and start
        @(negedge clk);
        alu_done = 1'b1;
        in_valid = 1'b1; in_opcode = OP; in_rd = 5'd1;
        #1 chk("stale_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("stale_start", 32'(alu_start), 32'd0);
        chk("stale_busy", 32'(busy), 32'd0);
        $display("txn STALE  done held high in IDLE, in_ready=%0b start=%0b", in_ready, alu_start);
        @(negedge clk); in_valid = 1'b0; alu_done = 1'b0;

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        in_valid = 1'b1; in_opcode = OP; in_fun3 = 3'd0; in_rs1 = 32'd1; in_rs2 = 32'd1; in_rd = 5'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rrun_start", 32'(alu_start), 32'd1);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rrun_start_lo", 32'(alu_start), 32'd0);
        chk("rrun_wb_valid", 32'(wb_valid), 32'd0);
        chk("rrun_busy", 32'(busy), 32'd0);
        chk("rrun_in_ready", 32'(in_ready), 32'd0);
        chk("rrun_wb_rd", 32'(wb_rd), 32'd0);
        $display("txn RESET  asynchronous reset during RUN, start=%0b busy=%0b", alu_start, busy);
        @(negedge clk); reset = 1'b0;
        do_txn(OP, 3'd7, 7'h00, 32'hFF00FF00, 32'h0FF00FF0, 12'h000, 5'd11, 1, 1);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      opc = OP;
            else if (r < 8) opc = OPIMM;
            else            opc = bad_opc[$urandom_range(0, 3)];
            r = $urandom_range(0, 9);
            lat = (r == 0) ? 0 : (r == 1) ? TO : $urandom_range(1, 4);
            do_txn(opc, 3'($urandom), ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00,
                   $urandom, $urandom, 12'($urandom), 5'($urandom), lat, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
